// File: rtl/prim_pad_bank_ctrl_if.sv
// Signal bundle between the core/peripheral side and the pad control bank.
// The master drives core-side requests and the raw pad input. The slave (the bank) returns pad and core outputs.
interface prim_pad_bank_ctrl_if #(
    parameter int NumPads = 8
);
    logic [NumPads-1:0] core_out_i;
    logic [NumPads-1:0] core_oe_i;
    logic [NumPads-1:0] core_ie_i;
    logic [NumPads-1:0] invert_i;
    logic [NumPads-1:0] virt_od_en_i;
    logic [NumPads-1:0] filt_en_i;
    logic [NumPads-1:0] keep_en_i;
    logic [NumPads-1:0] pad_in_i;
    logic [NumPads-1:0] pad_out_o;
    logic [NumPads-1:0] pad_oe_o;
    logic [NumPads-1:0] pad_ie_o;
    logic [NumPads-1:0] core_in_o;
    logic [NumPads-1:0] rise_o;
    logic [NumPads-1:0] fall_o;
    logic [NumPads-1:0] turn_busy_o;

    modport master (
        output core_out_i, core_oe_i, core_ie_i, invert_i, virt_od_en_i,
               filt_en_i, keep_en_i, pad_in_i,
        input  pad_out_o, pad_oe_o, pad_ie_o, core_in_o, rise_o, fall_o,
               turn_busy_o
    );

    modport slave (
        input  core_out_i, core_oe_i, core_ie_i, invert_i, virt_od_en_i,
               filt_en_i, keep_en_i, pad_in_i,
        output pad_out_o, pad_oe_o, pad_ie_o, core_in_o, rise_o, fall_o,
               turn_busy_o
    );
endinterface

// File: rtl/prim_pad_bank_ctrl.sv
// Per-pad control bank: output-enable turnaround with virtual open drain, and an
// input conditioning chain (synchroniser, inversion, glitch filter, keeper, edge detect).
module prim_pad_bank_ctrl #(
    parameter int NumPads    = 8,
    parameter int FiltCycles = 4,
    parameter int TurnCycles = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    prim_pad_bank_ctrl_if.slave bus
);
    localparam int CNT_W = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;
    localparam int FC_W  = $clog2(FiltCycles + 1);

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TurnCycles > 0) ? TurnCycles - 1 : 0);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FiltCycles - 1);

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2
    } dir_e;

    // Filter counter next value: restart on agreement, acceptance or disabled input.
    function automatic logic [FC_W-1:0] fc_next(
        input logic            ie,
        input logic            differ,
        input logic            accept,
        input logic [FC_W-1:0] fc
    );
        if (!ie || !differ || accept) begin
            return '0;
        end
        return fc + FC_W'(1);
    endfunction

    logic [NumPads-1:0] pad_out;
    logic [NumPads-1:0] drive_st;
    logic [NumPads-1:0] turn_st;
    logic [NumPads-1:0] sync_p0;
    logic [NumPads-1:0] sync_p1;
    logic [NumPads-1:0] x_p1;
    logic [NumPads-1:0] q_vec;
    logic [NumPads-1:0] rise_vec;
    logic [NumPads-1:0] fall_vec;

    assign pad_out = bus.core_out_i ^ bus.invert_i;

    // Stage p0/p1: two-flop synchroniser; keeps sampling even while input is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= bus.pad_in_i;
            sync_p1 <= sync_p0;
        end
    end

    assign x_p1 = sync_p1 ^ bus.invert_i;

    for (genvar p = 0; p < NumPads; p++) begin : g_pad
        dir_e             state_q;
        dir_e             state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             q_q;
        logic [FC_W-1:0]  fc_q;
        logic             rise_q;
        logic             fall_q;
        logic             differ;
        logic             accept;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= HIZ;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                HIZ: begin
                    if (bus.core_oe_i[p]) begin
                        if (TurnCycles == 0) begin
                            state_d = DRIVE;
                        end else begin
                            state_d = TURN;
                            cnt_d   = TURN_LOAD;
                        end
                    end
                end
                TURN: begin
                    if (!bus.core_oe_i[p]) begin
                        state_d = HIZ;
                    end else if (cnt_q == '0) begin
                        state_d = DRIVE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (!bus.core_oe_i[p]) begin
                        state_d = HIZ;
                    end
                end
                default: state_d = HIZ;
            endcase
        end

        assign drive_st[p] = (state_q == DRIVE);
        assign turn_st[p]  = (state_q == TURN);

        // A mismatch is taken at once when unfiltered, else after FiltCycles stable cycles.
        assign differ = (x_p1[p] != q_q);
        assign accept = bus.core_ie_i[p] && differ &&
                        (!bus.filt_en_i[p] || (fc_q == FC_LAST));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q_q    <= 1'b0;
                fc_q   <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                if (accept) begin
                    q_q <= x_p1[p];
                end
                fc_q   <= fc_next(bus.core_ie_i[p], differ, accept, fc_q);
                rise_q <= accept & x_p1[p];
                fall_q <= accept & ~x_p1[p];
            end
        end

        assign q_vec[p]    = q_q;
        assign rise_vec[p] = rise_q;
        assign fall_vec[p] = fall_q;
    end

    // Release is immediate; open-drain emulation only ever drives a low level.
    assign bus.pad_out_o   = pad_out;
    assign bus.pad_oe_o    = drive_st & bus.core_oe_i & ~(bus.virt_od_en_i & pad_out);
    assign bus.pad_ie_o    = bus.core_ie_i;
    assign bus.turn_busy_o = turn_st;
    assign bus.core_in_o   = q_vec & (bus.core_ie_i | bus.keep_en_i);
    assign bus.rise_o      = rise_vec & bus.core_ie_i;
    assign bus.fall_o      = fall_vec & bus.core_ie_i;
endmodule

// File: tb/tb_prim_pad_bank_ctrl.sv
// Self-checking bench for prim_pad_bank_ctrl: a vector table driven through a scoreboard
// queue, plus directed sequences for reset, same-cycle OE release and async reset.
module tb_prim_pad_bank_ctrl;
    localparam int NP = 8;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   failures = 0;

    prim_pad_bank_ctrl_if #(.NumPads(NP)) bus ();

    prim_pad_bank_ctrl #(
        .NumPads   (NP),
        .FiltCycles(4),
        .TurnCycles(2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] oe, out, ie, inv, od, filt, keep, pad;
        logic [7:0] e_oe, e_busy, e_in, e_rise, e_fall;
    } vec_t;

    vec_t tbl[$];
    vec_t expq[$];

    function automatic vec_t mk(
        input logic [7:0] oe, out, ie, inv, od, filt, keep, pad,
        input logic [7:0] e_oe, e_busy, e_in, e_rise, e_fall
    );
        vec_t v;
        v.oe = oe; v.out = out; v.ie = ie; v.inv = inv; v.od = od;
        v.filt = filt; v.keep = keep; v.pad = pad;
        v.e_oe = e_oe; v.e_busy = e_busy; v.e_in = e_in;
        v.e_rise = e_rise; v.e_fall = e_fall;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.core_oe_i    = v.oe;
        bus.core_out_i   = v.out;
        bus.core_ie_i    = v.ie;
        bus.invert_i     = v.inv;
        bus.virt_od_en_i = v.od;
        bus.filt_en_i    = v.filt;
        bus.keep_en_i    = v.keep;
        bus.pad_in_i     = v.pad;
    endtask

    task automatic apply_row(input int idx, input vec_t v);
        vec_t e;
        drive(v);
        expq.push_back(v);
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL row%0d scoreboard empty", idx);
        end else begin
            e = expq.pop_front();
            check($sformatf("row%0d pad_oe", idx), bus.pad_oe_o, e.e_oe);
            check($sformatf("row%0d turn_busy", idx), bus.turn_busy_o, e.e_busy);
            check($sformatf("row%0d core_in", idx), bus.core_in_o, e.e_in);
            check($sformatf("row%0d rise", idx), bus.rise_o, e.e_rise);
            check($sformatf("row%0d fall", idx), bus.fall_o, e.e_fall);
            check($sformatf("row%0d pad_out", idx), bus.pad_out_o, e.out ^ e.inv);
            check($sformatf("row%0d pad_ie", idx), bus.pad_ie_o, e.ie);
        end
    endtask

    initial begin
        // columns: oe out ie inv od filt keep pad | exp pad_oe busy core_in rise fall
        // OE request, turnaround of two cycles
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        // turnaround abort
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        // virtual open drain
        tbl.push_back(mk(1,0,0,0,1,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        // filter on: 3-cycle glitch suppressed
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,1,0,0,1,0,1, 0,0,0,0,0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,1,0,0,1,0,0, 0,0,0,0,0));
        // filter on: stable high accepted after edge 6
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,1,0,0,1,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,1,0,1, 0,0,1,1,0));
        tbl.push_back(mk(0,0,1,0,0,1,0,1, 0,0,1,0,0));
        // filter off: changes after edge 3
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,1, 0,0,1,1,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,1, 0,0,1,0,0));
        // keeper while input disabled, pad falls meanwhile
        tbl.push_back(mk(0,0,0,0,0,0,1,1, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,0,0,0));
        // inversion toggles, filter off
        tbl.push_back(mk(0,0,1,1,0,0,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,1,1,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,0,0,0));
        // inversion toggle filtered, then filter disabled mid-count
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,1,1,0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,0,1,0,0, 0,0,1,1,0));
        tbl.push_back(mk(0,0,1,1,0,1,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,0,1,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,0,1,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,0,0,0, 0,0,0,0,0));

        // Reset state with busy inputs applied
        drive(mk(8'hFF,8'hA5,8'h3C,8'h0F,8'h00,8'hFF,8'hFF,8'hFF, 0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        check("reset pad_out", bus.pad_out_o, 8'hAA);
        check("reset pad_ie", bus.pad_ie_o, 8'h3C);
        check("reset pad_oe", bus.pad_oe_o, 8'h00);
        check("reset turn_busy", bus.turn_busy_o, 8'h00);
        check("reset core_in", bus.core_in_o, 8'h00);
        check("reset rise", bus.rise_o, 8'h00);
        check("reset fall", bus.fall_o, 8'h00);
        drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply_row(i, tbl[i]);
            if (i == 3) begin
                bus.core_oe_i = 8'h00;
                #1;
                check("oe same-cycle release", bus.pad_oe_o, 8'h00);
            end
        end

        // Async reset with pad0 in DRIVE, pad1 in TURN, pad2 freshly accepted high
        drive(mk(8'h01,8'h00,8'h04,0,0,0,0,8'h04, 0,0,0,0,0));
        @(posedge clk);
        #1;
        bus.core_oe_i = 8'h03;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset pad_oe", bus.pad_oe_o, 8'h01);
        check("pre-reset turn_busy", bus.turn_busy_o, 8'h02);
        check("pre-reset core_in", bus.core_in_o, 8'h04);
        check("pre-reset rise", bus.rise_o, 8'h04);
        bus.core_out_i = 8'h02;
        #2;
        rst_ni = 1'b0;
        #1;
        check("async reset pad_oe", bus.pad_oe_o, 8'h00);
        check("async reset turn_busy", bus.turn_busy_o, 8'h00);
        check("async reset core_in", bus.core_in_o, 8'h00);
        check("async reset rise", bus.rise_o, 8'h00);
        check("async reset pad_out", bus.pad_out_o, 8'h02);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset turn_busy", bus.turn_busy_o, 8'h03);
        check("post-reset pad_oe", bus.pad_oe_o, 8'h00);
        check("post-reset core_in", bus.core_in_o, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prim_pad_bank_ctrl.md
# prim_pad_bank_ctrl

Parametrised, clocked control bank placed between core peripherals and a row of `NumPads` generic pad wrappers.
- Output side: per-pad bus-turnaround sequencing and virtual open-drain emulation.
- Input side: synchronisation, inversion, glitch filtering, keeper hold and edge detection.
- Pad-facing outputs drive each pad wrapper's `out_i`, `oe_i` and `ie_i`. The wrapper's `in_raw_o` returns on `pad_in_i`.

## Interface
- `NumPads`, 8: number of pad channels, ≥1.
- `FiltCycles`, 4: consecutive stable cycles needed to accept a filtered input change, ≥1.
- `TurnCycles`, 2: dead cycles between an output-enable request and the pad actually driving, ≥0.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `core_out_i`  in  NumPads  output data from core.
- `core_oe_i`  in  NumPads  output-enable request.
- `core_ie_i`  in  NumPads  input enable.
- `invert_i`  in  NumPads  per-pad data inversion, applied in both directions.
- `virt_od_en_i`  in  NumPads  virtual open-drain enable.
- `filt_en_i`  in  NumPads  glitch filter enable.
- `keep_en_i`  in  NumPads  keeper: hold last accepted value while input disabled.
- `pad_in_i`  in  NumPads  raw pad input, asynchronous.
- `pad_out_o`  out  NumPads  pad output data.
- `pad_oe_o`  out  NumPads  pad output enable.
- `pad_ie_o`  out  NumPads  pad input enable.
- `core_in_o`  out  NumPads  conditioned input to core.
- `rise_o`  out  NumPads  one-cycle pulse on accepted 0→1.
- `fall_o`  out  NumPads  one-cycle pulse on accepted 1→0.
- `turn_busy_o`  out  NumPads  pad is in turnaround state.

## Operation
The output path is per pad.
- `pad_out_o = core_out_i ^ invert_i`, combinational.
- Direction FSM states:
  - HIZ: if `core_oe_i`, go to TURN with `cnt=TurnCycles-1`. If `TurnCycles==0`, go directly to DRIVE.
  - TURN: if `!core_oe_i`, go to HIZ. Else if `cnt==0`, go to DRIVE. Else decrement `cnt`.
  - DRIVE: if `!core_oe_i`, go to HIZ.
- `pad_oe_o = (state==DRIVE) & core_oe_i & ~(virt_od_en_i & pad_out_o)`.
  - Release is combinational in the same cycle; assertion is delayed by the FSM.
  - Open-drain gating is combinational and is not subject to turnaround.
- `turn_busy_o = (state==TURN)`.

The input path is per pad.
- `pad_ie_o = core_ie_i`.
- A 2-flop synchroniser on `pad_in_i` produces `s`. Then `x = s ^ invert_i`.
- Accepted state `q` and counter `fc` (width `$clog2(FiltCycles+1)`) update only while `core_ie_i=1`:
  - `x==q`: `fc` ← 0.
  - `x!=q` and (`!filt_en_i` or `fc==FiltCycles-1`): `q` ← `x`, `fc` ← 0.
  - Otherwise: `fc` ← `fc+1`.
- While `core_ie_i=0`: `q` holds and `fc` ← 0. Synchroniser flops keep sampling.
- `core_in_o = q` when `core_ie_i`; else `keep_en_i ? q : 0`.
- `rise_o` and `fall_o` are registered: they assert in the first cycle `q` shows its new value, for exactly one cycle. They never assert while `core_ie_i=0`.
- Toggling `invert_i` is treated as an input change and is filtered normally.
- Toggling `filt_en_i` to 0 with `fc>0`: the next mismatching cycle is accepted immediately.

## Timing
- Reset values: sync flops 0, `q=0`, `fc=0`, FSM=HIZ, `rise_o=fall_o=0`, `turn_busy_o=0`, `pad_oe_o=0`. `core_in_o=0`.
- `pad_out_o` and `pad_ie_o` follow their inputs combinationally, including during reset.
- OE latency: `core_oe_i` high sampled at edge 1 → `pad_oe_o` high after edge `1+TurnCycles`. With `TurnCycles=0`, it is high after edge 1.
- OE release: same cycle as `core_oe_i` falling.
- Input latency, filter off: `pad_in_i` change settled before edge 1 → `core_in_o` changes after edge 3.
- Input latency, filter on: `core_in_o` changes after edge `2+FiltCycles`.
- A glitch shorter than `FiltCycles` cycles at `x` is suppressed, and `fc` restarts.
- A simultaneous pad change and `core_ie_i` fall: no update, no pulse.
- Asynchronous reset mid-turnaround or mid-filter: all state returns to reset values immediately, and `pad_oe_o` drops at once.
- Channels are fully independent; no shared state.

## Test plan
- **Reset, then OE request:** `TurnCycles=2`, `core_oe_i[0]` 0→1 before edge 1 → `turn_busy_o[0]` high after edges 1–2, `pad_oe_o[0]` high after edge 3. Dropping `core_oe_i[0]` clears `pad_oe_o[0]` the same cycle.
- **Turnaround abort:** `core_oe_i` high for 1 cycle only → FSM TURN→HIZ, `pad_oe_o` never asserts.
- **Virtual open drain:** `virt_od_en_i=1`, DRIVE state, `core_out_i` toggles 0/1 → `pad_oe_o` toggles 1/0, `pad_out_o` follows.
- **Filter:** `FiltCycles=4`, `filt_en_i=1`.
  - A 3-cycle high pulse on `pad_in_i` → `core_in_o` stays 0, no `rise_o`.
  - A 4-cycle stable high → `core_in_o` 1 after edge 6, with `rise_o` for one cycle.
  - With filter off, `core_in_o` is 1 after edge 3.
- **Keeper:** `q=1`, `core_ie_i` 1→0 → `core_in_o` stays 1 with `keep_en_i=1`, drops to 0 with `keep_en_i=0`. A pad change meanwhile gives no pulse.
- **Reset mid-operation:** assert `rst_ni` low during TURN with `fc=2` → all outputs go to reset values asynchronously.
